arrow_spawner: RTL and testbench

ARROW_SPAWNER -- requirements
Module: arrow_spawner

---
 rtl/game_pkg.sv | 36 +++
 rtl/lfsr16.sv | 34 +++
 rtl/arrow_spawner.sv | 186 ++++++++++++++++++
 tb/tb_arrow_spawner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: FSM states, arrow direction codes, frame-tick position
// and the spawn LFSR polynomial.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } game_state_e;

  localparam logic [1:0] DirTop    = 2'b00;
  localparam logic [1:0] DirBottom = 2'b01;
  localparam logic [1:0] DirLeft   = 2'b10;
  localparam logic [1:0] DirRight  = 2'b11;

  localparam logic [10:0] TickHcount = 11'd0;
  localparam logic [9:0]  TickVcount = 10'd0;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned IntervalStep = 5;

  // Only vertical arrows may be inversed
  function automatic logic inversed_for(input logic [1:0] dir, input logic flag);
    logic res;
    res = 1'b0;
    unique case (dir)
      DirTop, DirBottom: res = flag;
      DirLeft, DirRight: res = 1'b0;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load; load has priority over advance.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (advance) begin
      value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LfsrTaps : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/arrow_spawner.sv
// Arrow game controller: spawns arrows into free slots on a frame-based interval,
// tracks blocks (score) and player hits (lives), and runs the IDLE/RUN/OVER flow.
module arrow_spawner
  import game_pkg::*;
#(
  parameter int unsigned NUM_ARROWS    = 4,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned INIT_INTERVAL = 60,
  parameter int unsigned MIN_INTERVAL  = 15,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      start_in,
  input  logic [NUM_ARROWS-1:0]     arrow_hit_in,
  input  logic [NUM_ARROWS-1:0]     player_hit_in,
  output logic [NUM_ARROWS-1:0]     arrow_valid_out,
  output logic [2*NUM_ARROWS-1:0]   direction_out,
  output logic [3*NUM_ARROWS-1:0]   speed_out,
  output logic [NUM_ARROWS-1:0]     inversed_out,
  output logic [15:0]               score_out,
  output logic [1:0]                lives_out,
  output logic                      game_over_out
);

  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [15:0] interval_q, interval_d;
  logic [15:0] interval_next_q, interval_next_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [NUM_ARROWS-1:0]        valid_q, valid_d;
  logic [NUM_ARROWS-1:0][1:0]   dir_q, dir_d;
  logic [NUM_ARROWS-1:0][2:0]   speed_q, speed_d;
  logic [NUM_ARROWS-1:0]        inv_q, inv_d;
  logic [NUM_ARROWS-1:0]        hit_prev_q;

  logic                  frame_tick;
  logic                  running;
  logic                  start_run;
  logic [15:0]           lfsr_val;
  logic [NUM_ARROWS-1:0] hit_evt;
  logic [NUM_ARROWS-1:0] spawn_oh;
  logic [7:0]            n_block, n_player;
  logic [16:0]           score_sum;
  logic [15:0]           score_new;
  logic [1:0]            lives_new;
  logic [2:0]            spawn_speed;
  logic                  wrap;

  assign frame_tick = (hcount_in == TickHcount) && (vcount_in == TickVcount);
  assign running    = (state_q == StRun);
  assign start_run  = !running && start_in;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_run),
    .seed    (LFSR_SEED),
    .advance (running && frame_tick),
    .value   (lfsr_val)
  );

  // Rising edge of is_hit only, so a stale high level after respawn is ignored
  assign hit_evt  = valid_q & arrow_hit_in & ~hit_prev_q;
  // Lowest-index free slot as a one-hot vector (zero when all slots busy)
  assign spawn_oh = ~valid_q & (valid_q + 1'b1);
  assign wrap     = (frame_cnt_q == (interval_q - 16'd1));
  assign spawn_speed = (|score_q[15:6]) ? 3'd7 : score_q[5:3];

  always_comb begin
    n_block  = '0;
    n_player = '0;
    for (int i = 0; i < int'(NUM_ARROWS); i++) begin
      if (hit_evt[i]) begin
        if (player_hit_in[i]) n_player = n_player + 8'd1;
        else                  n_block  = n_block + 8'd1;
      end
    end
    score_sum = {1'b0, score_q} + {9'd0, n_block};
    score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    lives_new = (n_player >= {6'd0, lives_q}) ? 2'd0 : (lives_q - n_player[1:0]);
  end

  always_comb begin
    state_d         = state_q;
    lives_d         = lives_q;
    score_d         = score_q;
    interval_d      = interval_q;
    interval_next_d = interval_next_q;
    frame_cnt_d     = frame_cnt_q;
    valid_d         = valid_q;
    dir_d           = dir_q;
    speed_d         = speed_q;
    inv_d           = inv_q;

    unique case (state_q)
      StIdle, StOver: begin
        valid_d = '0;
        if (start_in) begin
          state_d         = StRun;
          lives_d         = 2'(START_LIVES);
          score_d         = '0;
          interval_d      = 16'(INIT_INTERVAL);
          interval_next_d = 16'(INIT_INTERVAL);
          frame_cnt_d     = '0;
          dir_d           = '0;
          speed_d         = '0;
          inv_d           = '0;
        end
      end
      StRun: begin
        valid_d = valid_q & ~hit_evt;
        lives_d = lives_new;
        score_d = score_new;
        if (score_new[15:3] != score_q[15:3]) begin
          interval_next_d = (interval_next_q >= 16'(MIN_INTERVAL + IntervalStep)) ?
                            (interval_next_q - 16'(IntervalStep)) : 16'(MIN_INTERVAL);
        end
        if (frame_tick) begin
          if (wrap) begin
            frame_cnt_d = '0;
            interval_d  = interval_next_d;
            for (int i = 0; i < int'(NUM_ARROWS); i++) begin
              if (spawn_oh[i]) begin
                valid_d[i] = 1'b1;
                dir_d[i]   = lfsr_val[1:0];
                inv_d[i]   = inversed_for(lfsr_val[1:0], lfsr_val[2]);
                speed_d[i] = spawn_speed;
              end
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
        if (lives_new == 2'd0) begin
          state_d = StOver;
          valid_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      lives_q         <= 2'(START_LIVES);
      score_q         <= '0;
      interval_q      <= 16'(INIT_INTERVAL);
      interval_next_q <= 16'(INIT_INTERVAL);
      frame_cnt_q     <= '0;
      valid_q         <= '0;
      dir_q           <= '0;
      speed_q         <= '0;
      inv_q           <= '0;
      hit_prev_q      <= '0;
    end else begin
      state_q         <= state_d;
      lives_q         <= lives_d;
      score_q         <= score_d;
      interval_q      <= interval_d;
      interval_next_q <= interval_next_d;
      frame_cnt_q     <= frame_cnt_d;
      valid_q         <= valid_d;
      dir_q           <= dir_d;
      speed_q         <= speed_d;
      inv_q           <= inv_d;
      hit_prev_q      <= arrow_hit_in;
    end
  end

  assign arrow_valid_out = valid_q;
  assign direction_out   = dir_q;
  assign speed_out       = speed_q;
  assign inversed_out    = inv_q;
  assign score_out       = score_q;
  assign lives_out       = lives_q;
  assign game_over_out   = (state_q == StOver);

endmodule

// File: tb/tb_arrow_spawner.sv
// Directed bench for arrow_spawner: spawn timing, scoring, lives, interval step,
// stale-hit filtering, reset and game-over behaviour.
module tb_arrow_spawner;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        start;
  logic [3:0]  arrow_hit;
  logic [3:0]  player_hit;
  logic [3:0]  valid;
  logic [7:0]  direction;
  logic [11:0] speed;
  logic [3:0]  inversed;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  logic [15:0] v;
  logic [1:0]  exp_dir;
  logic        exp_inv;

  always #5 clk = ~clk;

  arrow_spawner dut (
    .clk             (clk),
    .rst             (rst),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .start_in        (start),
    .arrow_hit_in    (arrow_hit),
    .player_hit_in   (player_hit),
    .arrow_valid_out (valid),
    .direction_out   (direction),
    .speed_out       (speed),
    .inversed_out    (inversed),
    .score_out       (score),
    .lives_out       (lives),
    .game_over_out   (game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hcount = 11'd0;
      vcount = 10'd0;
      @(negedge clk);
      hcount = 11'd7;
      vcount = 10'd3;
      @(negedge clk);
    end
  endtask

  task automatic hit(input logic [3:0] h, input logic [3:0] p);
    arrow_hit  = h;
    player_hit = p;
    @(negedge clk);
    arrow_hit  = '0;
    player_hit = '0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    hcount     = 11'd7;
    vcount     = 10'd3;
    arrow_hit  = '0;
    player_hit = '0;
    v = 16'hACE1;
    for (int i = 0; i < 59; i++) v = lfsr_step(v);
    exp_dir = v[1:0];
    exp_inv = (v[1] == 1'b0) && v[2];

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_gameover", 32'(game_over), 32'h0);
    check("rst_dir", 32'(direction), 32'h0);
    check("rst_speed", 32'(speed), 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    ticks(60);
    check("idle_no_spawn", 32'(valid), 32'h0);

    // First game
    pulse_start();
    ticks(59);
    check("tick59_no_spawn", 32'(valid), 32'h0);
    ticks(1);
    check("tick60_spawn", 32'(valid), 32'b0001);
    check("spawn_dir", 32'(direction[1:0]), 32'(exp_dir));
    check("spawn_inv", 32'(inversed[0]), 32'(exp_inv));
    check("spawn_speed", 32'(speed[2:0]), 32'h0);
    check("lives_3", 32'(lives), 32'd3);

    hit(4'b0001, 4'b0000);
    check("block_score", 32'(score), 32'd1);
    check("block_valid", 32'(valid), 32'h0);

    ticks(60); check("fill_0", 32'(valid), 32'b0001);
    ticks(60); check("fill_1", 32'(valid), 32'b0011);
    ticks(60); check("fill_2", 32'(valid), 32'b0111);
    ticks(60); check("fill_3", 32'(valid), 32'b1111);
    ticks(60); check("full_drop", 32'(valid), 32'b1111);

    hit(4'b0001, 4'b0000);
    check("score_2", 32'(score), 32'd2);
    ticks(59); check("cnt_wrapped_59", 32'(valid), 32'b1110);
    ticks(1);  check("cnt_wrapped_60", 32'(valid), 32'b1111);

    hit(4'b0110, 4'b0010);
    check("multi_score", 32'(score), 32'd3);
    check("multi_lives", 32'(lives), 32'd2);
    check("multi_valid", 32'(valid), 32'b1001);

    hit(4'b1001, 4'b0000);
    check("score_5", 32'(score), 32'd5);
    ticks(180);
    check("refill", 32'(valid), 32'b0111);
    hit(4'b0111, 4'b0000);
    check("score_8", 32'(score), 32'd8);
    ticks(60);
    check("spawn_after_8", 32'(valid), 32'b0001);
    check("speed_1", 32'(speed[2:0]), 32'd1);
    ticks(54);
    check("int55_no_spawn", 32'(valid), 32'b0001);
    ticks(1);
    check("int55_spawn", 32'(valid), 32'b0011);

    // Stale is_hit left high across a respawn
    arrow_hit = 4'b0001;
    @(negedge clk);
    check("score_9", 32'(score), 32'd9);
    check("slot0_free", 32'(valid), 32'b0010);
    ticks(55);
    check("respawn", 32'(valid), 32'b0011);
    @(negedge clk);
    @(negedge clk);
    check("stale_score", 32'(score), 32'd9);
    check("stale_valid", 32'(valid), 32'b0011);
    arrow_hit = '0;
    @(negedge clk);

    pulse_start();
    @(negedge clk);
    check("start_ign_score", 32'(score), 32'd9);
    check("start_ign_lives", 32'(lives), 32'd2);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_score", 32'(score), 32'h0);
    check("midrst_lives", 32'(lives), 32'd3);
    ticks(60);
    check("midrst_idle", 32'(valid), 32'h0);

    // Second game to game over
    pulse_start();
    ticks(60);
    check("g2_spawn", 32'(valid), 32'b0001);
    check("g2_dir", 32'(direction[1:0]), 32'(exp_dir));
    ticks(120);
    check("g2_fill", 32'(valid), 32'b0111);
    hit(4'b0001, 4'b0001);
    check("lives_2", 32'(lives), 32'd2);
    check("lives_2_valid", 32'(valid), 32'b0110);
    hit(4'b0010, 4'b0010);
    check("lives_1", 32'(lives), 32'd1);
    hit(4'b0100, 4'b0100);
    check("lives_0", 32'(lives), 32'd0);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_valid", 32'(valid), 32'h0);
    check("over_score", 32'(score), 32'h0);
    hit(4'b1111, 4'b1010);
    check("over_ign_lives", 32'(lives), 32'd0);
    check("over_ign_score", 32'(score), 32'h0);
    ticks(60);
    check("over_no_spawn", 32'(valid), 32'h0);
    pulse_start();
    check("restart_over", 32'(game_over), 32'h0);
    check("restart_lives", 32'(lives), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
